vec_int_ctrl: RTL and testbench
===============================

# vec_int_ctrl

Vectored interrupt controller that arbitrates the peripheral `done` lines and sequences the single-cycle MIPS core's interrupt entry and return. It edge-detects and latches requests, applies a per-source mask, and picks the highest-priority pending source. It drives the core's `int_ack`, `epcwrite`, `int_addr` and `status_bit`, replacing the combinational interrupt encoder and vector mux. It tracks in-service state until the core executes `jepc`.

## Interface
- `NSRC`, 4: number of interrupt sources; 2..8.
- `VEC_BASE`, 32'h0000_01F0: byte address of the vector for source 0; source i vector = `VEC_BASE + 4*i`.
- `clk` in 1: core clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `done` in NSRC: peripheral completion lines (level); bit 0 = highest priority.
- `mask_we` in 1: write strobe for the enable mask.
- `mask_wd` in NSRC: new mask value; 1 = source enabled.
- `eret` in 1: core is executing `jepc` this cycle (the `status_write` decode).
- `int_ack` out 1: one-cycle pulse; core selects `int_addr` as next PC.
- `epcwrite` out 1: identical to `int_ack`; core captures its pcnext into EPC.
- `int_addr` out 32: vector of the source being acknowledged; valid while `int_ack`=1, else 0.
- `status_bit` out 1: 1 = controller idle and able to deliver.
- `pending` out NSRC: latched request bits.
- `active_id` out 3: source currently in service (low log2(NSRC) bits used).
- `in_service` out 1: an ISR is running.

## Operation
- Edge detect: `done_q` register (reset 0). A source's rise is `done & ~done_q`; a line held high at reset release counts as a rise in the first cycle.
- A rise sets `pending[i]`. Pending latches regardless of mask.
- A pending bit clears only on the edge that leaves ACK for that source.
- If a rise and the clear of the same bit hit the same edge, set wins and the bit stays 1.
- Mask register resets to all ones. When `mask_we`=1, `mask <= mask_wd`. Masking gates delivery only.
- Eligible = `pending & mask`. Winner = lowest set index. The winner comes from the priority encoder.
- FSM states:
  - IDLE: if eligible != 0, capture winner into `active_id` and go to ACK.
  - ACK: `int_ack`=`epcwrite`=1 and `int_addr` = vector(`active_id`). Clear `pending[active_id]`. Always go to SERVICE next cycle.
  - SERVICE: wait for `eret`; on `eret` go to IDLE. New requests keep latching; no nesting.
- `eret` in IDLE or ACK is ignored.
- `status_bit` = (state==IDLE). `in_service` = (state==SERVICE).
- Reset (at any time, including mid-ACK or mid-SERVICE) forces:
  - state IDLE;
  - `pending`=0, `done_q`=0, mask=all ones, `active_id`=0;
  - `int_ack`=`epcwrite`=0, `int_addr`=0;
  - `status_bit`=1, `in_service`=0.

## Timing
- Request latency: rise sampled at edge N → `pending` set after N. If IDLE, ACK begins after edge N+1 and `int_ack` is high for exactly the cycle N+1..N+2. SERVICE begins after N+2.
- In that ACK cycle `int_addr` and `int_ack` are Moore outputs decoded from registered state only, with no combinational path from `done` or `eret`.
- `eret` sampled at edge M in SERVICE → IDLE after M. If eligible != 0, the next ACK begins after M+1, giving a minimum of one IDLE cycle between ISRs.
- A mask write at edge K affects arbitration from the cycle after K.
- Arbitration in IDLE uses the current registered pending and mask. A winner captured into ACK is not re-arbitrated.

## Structure
- Shared package `vec_int_pkg` holds:
  - state encoding constants IDLE=2'd0, ACK=2'd1, SERVICE=2'd2 (2'd3 illegal → IDLE);
  - default `NSRC` and `VEC_BASE`.
- One sub-module, `prio_enc`, parameterized by `NSRC`:
  - input request vector;
  - outputs `valid` and the lowest set index.
- Top level holds the edge detector, pending/mask registers, FSM and vector adder.

## Test plan
- Reset, then pulse `done[1]` for one cycle: `pending`=4'b0010 next cycle, then one `int_ack` cycle with `int_addr`=32'h1F4 and `status_bit`=0. `pending`=0 after ACK. `eret` → `status_bit`=1.
- Raise `done[3]` and `done[0]` on the same edge: first ACK has `int_addr`=32'h1F0. After `eret`, one IDLE cycle, then ACK with `int_addr`=32'h1FC.
- Mask 4'b1101, pulse `done[1]`: `pending[1]`=1 and no `int_ack`. Write mask 4'b1111 → ACK with 32'h1F4 two cycles later.
- During SERVICE pulse `done[2]`: no ACK until `eret`. Then ACK with 32'h1F8. A rise of `done[2]` coincident with its own ACK leaves `pending[2]`=1 and produces a second ACK.
- Assert `reset` mid-SERVICE with `pending`=4'b0100: all outputs return to reset values, `status_bit`=1, and no ACK follows. Hold `done[0]` high through reset release → ACK with 32'h1F0.

Source files
------------

// File: rtl/vec_int_pkg.sv
// Shared types and defaults for the vectored interrupt controller.
package vec_int_pkg;

   localparam int          DEF_NSRC     = 4;
   localparam logic [31:0] DEF_VEC_BASE = 32'h0000_01F0;

   // Controller sequencing states; 2'd3 is unused and recovers to IDLE.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACK     = 2'd1,
      SERVICE = 2'd2
   } state_t;

   // Vector address for a source: one word per source above the base.
   function automatic logic [31:0] vec_addr(input logic [31:0] base, input logic [2:0] idx);
      return base + {27'd0, idx, 2'b00};
   endfunction

endpackage

// File: rtl/vec_int_ctrl_prio_enc.sv
// Fixed-priority encoder: bit 0 is highest priority.
module prio_enc #(
   parameter int NSRC = 4
) (
   input  logic [NSRC-1:0] req,
   output logic            valid,
   output logic [2:0]      idx
);

   // Scan downward so the lowest set index is the last one written.
   always_comb begin
      valid = |req;
      idx   = 3'd0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (req[i]) idx = 3'(i);
      end
   end

endmodule

// File: rtl/vec_int_ctrl.sv
// Vectored interrupt controller: latches peripheral done edges, masks and
// arbitrates them, and sequences the core's interrupt entry and jepc return.
module vec_int_ctrl
   import vec_int_pkg::*;
#(
   parameter int          NSRC     = DEF_NSRC,
   parameter logic [31:0] VEC_BASE = DEF_VEC_BASE
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NSRC-1:0] done,
   input  logic            mask_we,
   input  logic [NSRC-1:0] mask_wd,
   input  logic            eret,
   output logic            int_ack,
   output logic            epcwrite,
   output logic [31:0]     int_addr,
   output logic            status_bit,
   output logic [NSRC-1:0] pending,
   output logic [2:0]      active_id,
   output logic            in_service
);

   state_t          state;
   logic [NSRC-1:0] done_q;
   logic [NSRC-1:0] mask;
   logic [NSRC-1:0] rise;
   logic [NSRC-1:0] ack_clr;
   logic            win_valid;
   logic [2:0]      win_idx;

   assign rise     = done & ~done_q;
   // Only the source being acknowledged is retired, and only while in ACK.
   assign ack_clr  = (state == ACK) ? (NSRC'(1) << active_id) : '0;
   assign epcwrite = int_ack;

   prio_enc #(.NSRC(NSRC)) u_prio_enc (
      .req   (pending & mask),
      .valid (win_valid),
      .idx   (win_idx)
   );

   // Edge-detect history and the software-written enable mask.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         done_q <= '0;
         mask   <= '1;
      end else begin
         done_q <= done;
         if (mask_we) mask <= mask_wd;
      end
   end

   // Request latch: a new rise beats the ACK clear of the same bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) pending <= '0;
      else       pending <= (pending & ~ack_clr) | rise;
   end

   // Entry/return sequencer with all core-facing outputs registered.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         active_id  <= 3'd0;
         int_ack    <= 1'b0;
         int_addr   <= 32'd0;
         status_bit <= 1'b1;
         in_service <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (win_valid) begin
                  state      <= ACK;
                  active_id  <= win_idx;
                  int_ack    <= 1'b1;
                  int_addr   <= vec_addr(VEC_BASE, win_idx);
                  status_bit <= 1'b0;
               end
            end
            ACK: begin
               state      <= SERVICE;
               int_ack    <= 1'b0;
               int_addr   <= 32'd0;
               in_service <= 1'b1;
            end
            SERVICE: begin
               if (eret) begin
                  state      <= IDLE;
                  in_service <= 1'b0;
                  status_bit <= 1'b1;
               end
            end
            default: begin
               state      <= IDLE;
               int_ack    <= 1'b0;
               int_addr   <= 32'd0;
               status_bit <= 1'b1;
               in_service <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vec_int_ctrl.sv
// Directed plus randomized bench for vec_int_ctrl against a cycle reference model.
module tb_vec_int_ctrl;

   localparam int          N  = 4;
   localparam logic [31:0] VB = 32'h0000_01F0;

   logic          clk;
   logic          reset;
   logic [N-1:0]  done;
   logic          mask_we;
   logic [N-1:0]  mask_wd;
   logic          eret;
   logic          int_ack;
   logic          epcwrite;
   logic [31:0]   int_addr;
   logic          status_bit;
   logic [N-1:0]  pending;
   logic [2:0]    active_id;
   logic          in_service;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: phase 0 = waiting, 1 = acknowledging, 2 = ISR running.
   logic [N-1:0] m_pend, m_mask, m_prev;
   int           m_phase, m_id;

   vec_int_ctrl #(.NSRC(N), .VEC_BASE(VB)) dut (
      .clk        (clk),
      .reset      (reset),
      .done       (done),
      .mask_we    (mask_we),
      .mask_wd    (mask_wd),
      .eret       (eret),
      .int_ack    (int_ack),
      .epcwrite   (epcwrite),
      .int_addr   (int_addr),
      .status_bit (status_bit),
      .pending    (pending),
      .active_id  (active_id),
      .in_service (in_service)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int lowest(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic model_reset();
      m_pend = '0; m_mask = '1; m_prev = '0; m_phase = 0; m_id = 0;
   endtask

   // One clock edge of the reference behaviour, using pre-edge values.
   task automatic model_edge();
      logic [N-1:0] rs, old_pend, old_mask;
      int           w;
      rs       = done & ~m_prev;
      old_pend = m_pend;
      old_mask = m_mask;
      m_prev   = done;
      if (m_phase == 1) m_pend[m_id] = 1'b0;
      m_pend = m_pend | rs;
      if (mask_we) m_mask = mask_wd;
      if (m_phase == 0) begin
         w = lowest(old_pend & old_mask);
         if (w >= 0) begin m_id = w; m_phase = 1; end
      end else if (m_phase == 1) begin
         m_phase = 2;
      end else if (eret) begin
         m_phase = 0;
      end
   endtask

   task automatic check_all();
      logic ack;
      ack = (m_phase == 1);
      chk("int_ack",    int_ack,    ack);
      chk("epcwrite",   epcwrite,   ack);
      chk("int_addr",   int_addr,   ack ? VB + 32'(4 * m_id) : 32'd0);
      chk("status_bit", status_bit, m_phase == 0);
      chk("in_service", in_service, m_phase == 2);
      chk("pending",    pending,    m_pend);
      chk("active_id",  active_id,  m_id);
   endtask

   // Apply inputs for one cycle (called at negedge), then check after the edge.
   task automatic cyc(input logic [N-1:0] d, input logic we, input logic [N-1:0] wd,
                      input logic er);
      done = d; mask_we = we; mask_wd = wd; eret = er;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
   endtask

   task automatic idle_n(input int n);
      for (int i = 0; i < n; i++) cyc('0, 1'b0, '0, 1'b0);
   endtask

   // Asynchronous reset asserted mid-cycle; done is left as driven.
   task automatic hard_reset();
      mask_we = 1'b0; eret = 1'b0;
      reset = 1'b1;
      #1;
      model_reset();
      check_all();
      @(posedge clk);
      @(negedge clk);
      check_all();
      reset = 1'b0;
   endtask

   initial begin
      done = '0; mask_we = 1'b0; mask_wd = '0; eret = 1'b0;
      reset = 1'b1;
      model_reset();
      @(negedge clk);
      check_all();
      reset = 1'b0;

      // Single request on source 1, then return.
      cyc(4'b0010, 1'b0, '0, 1'b0);
      chk("pend_after_rise", pending, 32'h2);
      cyc('0, 1'b0, '0, 1'b0);
      chk("ack_src1_addr", int_addr, 32'h1F4);
      idle_n(2);
      cyc('0, 1'b0, '0, 1'b1);
      chk("idle_after_eret", status_bit, 1'b1);
      idle_n(1);

      // Simultaneous sources 0 and 3: priority order, one idle gap between.
      cyc(4'b1001, 1'b0, '0, 1'b0);
      idle_n(3);
      cyc('0, 1'b0, '0, 1'b1);
      idle_n(3);
      cyc('0, 1'b0, '0, 1'b1);
      idle_n(1);

      // Masked source stays pending until re-enabled.
      cyc('0, 1'b1, 4'b1101, 1'b0);
      cyc(4'b0010, 1'b0, '0, 1'b0);
      idle_n(3);
      chk("masked_pending", pending, 32'h2);
      cyc('0, 1'b1, 4'b1111, 1'b0);
      idle_n(3);
      cyc('0, 1'b0, '0, 1'b1);
      idle_n(1);

      // No nesting; a rise coincident with its own ACK survives the clear.
      cyc(4'b0001, 1'b0, '0, 1'b0);
      idle_n(3);
      cyc(4'b0100, 1'b0, '0, 1'b0);
      idle_n(3);
      cyc('0, 1'b0, '0, 1'b1);
      for (int i = 0; i < 8 && m_phase != 1; i++) idle_n(1);
      cyc(4'b0100, 1'b0, '0, 1'b0);
      chk("coincident_set", pending[2], 1'b1);
      idle_n(2);
      cyc('0, 1'b0, '0, 1'b1);
      idle_n(4);
      cyc('0, 1'b0, '0, 1'b1);
      idle_n(1);

      // Reset mid-SERVICE with source 2 pending, then done[0] held through reset.
      cyc(4'b0001, 1'b0, '0, 1'b0);
      idle_n(2);
      cyc(4'b0100, 1'b0, '0, 1'b0);
      idle_n(1);
      hard_reset();
      idle_n(4);
      done = 4'b0001;
      hard_reset();
      cyc(4'b0001, 1'b0, '0, 1'b0);
      cyc(4'b0001, 1'b0, '0, 1'b0);
      chk("ack_after_held", int_addr, 32'h1F0);
      idle_n(2);
      cyc('0, 1'b0, '0, 1'b1);

      // Randomized traffic, with one reset dropped in the middle.
      for (int i = 0; i < 400; i++) begin
         if (i == 200) hard_reset();
         cyc(N'($urandom_range(0, 15)), $urandom_range(0, 15) == 0,
             N'($urandom_range(0, 15)), $urandom_range(0, 3) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
